// File: rtl/rv32i_types_pkg.sv
// Shared scalar-core types used by the vector datapath.
package rv32i_types_pkg;

  typedef enum logic [1:0] {
    SEW8  = 2'd0,
    SEW16 = 2'd1,
    SEW32 = 2'd2,
    SEW64 = 2'd3
  } sew_t;

endpackage

// File: rtl/rv32v_ex_mem_pkg.sv
// Types and sizing helpers for the execute-to-memory skid buffer.
package rv32v_ex_mem_pkg;

  // Occupancy is read straight off the state encoding, so keep EMPTY/MAIN/FULL = 0/1/2.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_MAIN  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam int unsigned EEW_W = $bits(rv32i_types_pkg::sew_t);

  // load + store + wen + storedata + aluresult + woffset + vd + eew + index + done
  function automatic int unsigned payload_width(input int unsigned lanes,
                                                input int unsigned off_w,
                                                input int unsigned cb_w);
    return 2 + lanes + 64 * lanes + lanes * off_w + 5 + EEW_W + cb_w + 1;
  endfunction

endpackage

// File: rtl/rv32v_pipe_reg.sv
// Enable-loaded register of parametric width with synchronous active-high clear.
module rv32v_pipe_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] data_d, data_q;

  always_comb begin
    data_d = data_q;
    if (en_i) data_d = d_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) data_q <= '0;
    else       data_q <= data_d;
  end

  assign q_o = data_q;

endmodule

// File: rtl/rv32v_ex_mem_skid_buffer.sv
// Two-entry execute-to-memory skid buffer carrying NUM_LANES vector lanes.
// Define RV32V_EXMEM_PERF_EN to add the stall_cycles back-pressure counter.
module rv32v_ex_mem_skid_buffer
  import rv32v_ex_mem_pkg::*;
#(
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned OFFSET_W  = 3,
  parameter int unsigned CB_IDX_W  = 3
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_load_ena,
  input  logic                          in_store_ena,
  input  logic [NUM_LANES-1:0]          in_wen,
  input  logic [NUM_LANES*32-1:0]       in_storedata,
  input  logic [NUM_LANES*32-1:0]       in_aluresult,
  input  logic [NUM_LANES*OFFSET_W-1:0] in_woffset,
  input  logic [4:0]                    in_vd,
  input  logic [EEW_W-1:0]              in_eew,
  input  logic [CB_IDX_W-1:0]           in_index,
  input  logic                          in_done,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_load_ena,
  output logic                          out_store_ena,
  output logic [NUM_LANES-1:0]          out_wen,
  output logic [NUM_LANES*32-1:0]       out_storedata,
  output logic [NUM_LANES*32-1:0]       out_aluresult,
  output logic [NUM_LANES*OFFSET_W-1:0] out_woffset,
  output logic [4:0]                    out_vd,
  output logic [EEW_W-1:0]              out_eew,
  output logic [CB_IDX_W-1:0]           out_index,
  output logic                          out_done,
  output logic [1:0]                    occupancy
`ifdef RV32V_EXMEM_PERF_EN
  ,
  output logic [31:0]                   stall_cycles
`endif
);

  localparam int unsigned PW = payload_width(NUM_LANES, OFFSET_W, CB_IDX_W);

  logic [PW-1:0] in_pl, main_d, main_q, skid_q;
  logic [1:0]    state_d, state_q;
  logic          push, pop, main_en, skid_en;

  assign in_pl = {in_load_ena, in_store_ena, in_wen, in_storedata, in_aluresult,
                  in_woffset, in_vd, in_eew, in_index, in_done};

  assign {out_load_ena, out_store_ena, out_wen, out_storedata, out_aluresult,
          out_woffset, out_vd, out_eew, out_index, out_done} = main_q;

  // in_ready depends on registered state only; out_ready never reaches it.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign occupancy = state_q;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    skid_en = 1'b0;
    main_d  = in_pl;
    unique case (state_q)
      ST_EMPTY: begin
        if (push) begin
          main_en = 1'b1;
          state_d = ST_MAIN;
        end
      end
      ST_MAIN: begin
        if (push && pop) begin
          main_en = 1'b1;
        end else if (push) begin
          skid_en = 1'b1;
          state_d = ST_FULL;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          main_en = 1'b1;
          main_d  = skid_q;
          state_d = ST_MAIN;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  rv32v_pipe_reg #(.Width(PW)) u_main (
    .clk_i (CLK),
    .rst_i (RST),
    .en_i  (main_en),
    .d_i   (main_d),
    .q_o   (main_q)
  );

  rv32v_pipe_reg #(.Width(PW)) u_skid (
    .clk_i (CLK),
    .rst_i (RST),
    .en_i  (skid_en),
    .d_i   (in_pl),
    .q_o   (skid_q)
  );

`ifdef RV32V_EXMEM_PERF_EN
  logic [31:0] stall_d, stall_q;

  // Saturating; flush deliberately leaves it alone.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_rv32v_ex_mem_skid_buffer.sv
// Self-checking bench for rv32v_ex_mem_skid_buffer (4 lanes), scoreboard plus vector table.
module tb_rv32v_ex_mem_skid_buffer;

  localparam int unsigned L  = 4;
  localparam int unsigned OW = 3;
  localparam int unsigned CW = 3;

  typedef struct packed {
    logic          load;
    logic          store;
    logic [L-1:0]  wen;
    logic [L*32-1:0] sd;
    logic [L*32-1:0] alu;
    logic [L*OW-1:0] wo;
    logic [4:0]    vd;
    logic [1:0]    eew;
    logic [CW-1:0] idx;
    logic          done;
  } pl_t;

  typedef struct {
    bit v;
    bit ordy;
    bit fl;
    int k;
    int exp_occ;
  } vec_t;

  logic CLK = 1'b0;
  logic RST, flush, in_valid, in_ready, out_valid, out_ready;
  logic out_load_ena, out_store_ena, out_done;
  logic [L-1:0] out_wen;
  logic [L*32-1:0] out_storedata, out_aluresult;
  logic [L*OW-1:0] out_woffset;
  logic [4:0] out_vd;
  logic [1:0] out_eew;
  logic [CW-1:0] out_index;
  logic [1:0] occupancy;
`ifdef RV32V_EXMEM_PERF_EN
  logic [31:0] stall_cycles;
  int unsigned stall_m;
`endif

  pl_t cur, got;
  pl_t sb[$];
  int total = 0;
  int bad   = 0;
  int occ_m = 0;

  always #5 CLK = ~CLK;

  assign got = {out_load_ena, out_store_ena, out_wen, out_storedata, out_aluresult,
                out_woffset, out_vd, out_eew, out_index, out_done};

  rv32v_ex_mem_skid_buffer #(
    .NUM_LANES (L),
    .OFFSET_W  (OW),
    .CB_IDX_W  (CW)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_load_ena   (cur.load),
    .in_store_ena  (cur.store),
    .in_wen        (cur.wen),
    .in_storedata  (cur.sd),
    .in_aluresult  (cur.alu),
    .in_woffset    (cur.wo),
    .in_vd         (cur.vd),
    .in_eew        (cur.eew),
    .in_index      (cur.idx),
    .in_done       (cur.done),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_load_ena  (out_load_ena),
    .out_store_ena (out_store_ena),
    .out_wen       (out_wen),
    .out_storedata (out_storedata),
    .out_aluresult (out_aluresult),
    .out_woffset   (out_woffset),
    .out_vd        (out_vd),
    .out_eew       (out_eew),
    .out_index     (out_index),
    .out_done      (out_done),
    .occupancy     (occupancy)
`ifdef RV32V_EXMEM_PERF_EN
    ,
    .stall_cycles  (stall_cycles)
`endif
  );

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic pl_t make_pl(input int k);
    pl_t p;
    logic [31:0] kk;
    kk = k;
    p = '0;
    for (int i = 0; i < L; i++) begin
      p.alu[32*i +: 32] = 32'h1000 * kk + i;
      p.sd[32*i +: 32]  = 32'hA5A5_0000 ^ (kk << 8) ^ i;
      p.wo[OW*i +: OW]  = OW'(kk + i);
    end
    p.wen   = kk[3:0];
    p.load  = kk[0];
    p.store = kk[1];
    p.done  = kk[2];
    p.vd    = kk[4:0];
    p.eew   = kk[1:0];
    p.idx   = kk[CW-1:0];
    return p;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, (occ_m != 2));
    chk({tag, "_out_valid"}, out_valid, (occ_m != 0));
    if (sb.size() > 0) chk({tag, "_payload"}, got, sb[0]);
`ifdef RV32V_EXMEM_PERF_EN
    chk({tag, "_stall"}, stall_cycles, stall_m);
`endif
  endtask

  // Drive one cycle, advance the scoreboard, then check after the edge.
  task automatic step(input bit v, input pl_t p, input bit ordy, input bit fl,
                      input int exp_occ, input string tag);
    bit push, pop;
    @(negedge CLK);
    in_valid  = v;
    cur       = p;
    out_ready = ordy;
    flush     = fl;
    push = v && (occ_m != 2) && !fl;
    pop  = (occ_m > 0) && ordy;
`ifdef RV32V_EXMEM_PERF_EN
    if ((occ_m > 0) && !ordy && (stall_m != 32'hFFFF_FFFF)) stall_m++;
`endif
    @(posedge CLK);
    #1;
    if (pop) void'(sb.pop_front());
    if (push) sb.push_back(p);
    if (fl) sb.delete();
    occ_m = sb.size();
    chk({tag, "_occupancy"}, occupancy, exp_occ);
    check_outputs(tag);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge CLK);
    RST = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    repeat (cycles) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    sb.delete();
    occ_m = 0;
`ifdef RV32V_EXMEM_PERF_EN
    stall_m = 0;
`endif
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_occupancy", occupancy, 2'd0);
    chk("rst_storedata", out_storedata, '0);
    chk("rst_payload", got, '0);
  endtask

  initial begin
    vec_t tbl[$];
    pl_t  p;

    RST = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    cur = '0;

    // streaming: one in, one out per cycle
    for (int k = 1; k <= 8; k++) tbl.push_back('{1, 1, 0, k, 1});
    tbl.push_back('{0, 1, 0, 0, 0});
    // back-pressure: A, B held, C refused, then drain
    tbl.push_back('{1, 0, 0, 20, 1});
    tbl.push_back('{1, 0, 0, 21, 2});
    tbl.push_back('{1, 0, 0, 22, 2});
    tbl.push_back('{0, 1, 0, 0, 1});
    tbl.push_back('{0, 1, 0, 0, 0});
    // flush while full with a concurrent push
    tbl.push_back('{1, 0, 0, 30, 1});
    tbl.push_back('{1, 0, 0, 31, 2});
    tbl.push_back('{1, 0, 1, 32, 0});
    tbl.push_back('{0, 0, 0, 0, 0});
    tbl.push_back('{1, 1, 0, 33, 1});
    tbl.push_back('{0, 1, 0, 0, 0});

    do_reset(2);

    foreach (tbl[n]) step(tbl[n].v, make_pl(tbl[n].k), tbl[n].ordy, tbl[n].fl,
                          tbl[n].exp_occ, $sformatf("vec%0d", n));

    // hold stability under 5 cycles of back-pressure
    p = make_pl(40);
    p.vd  = 5'd7;
    p.idx = 3'd3;
    step(1, p, 0, 0, 1, "hold_push");
    for (int c = 0; c < 5; c++) begin
      step(0, make_pl(41), 0, 0, 1, $sformatf("hold%0d", c));
      chk("hold_vd", out_vd, 5'd7);
      chk("hold_index", out_index, 3'd3);
    end
    step(0, make_pl(41), 1, 0, 0, "hold_drain");

    // reset mid-stream with two entries held
    step(1, make_pl(50), 0, 0, 1, "mrst_a");
    step(1, make_pl(51), 0, 0, 2, "mrst_b");
    do_reset(2);
    step(1, make_pl(52), 1, 0, 1, "post_rst_push");
    step(0, make_pl(0), 1, 0, 0, "post_rst_drain");

`ifdef RV32V_EXMEM_PERF_EN
    do_reset(1);
    step(1, make_pl(60), 0, 0, 1, "perf_push");
    for (int c = 0; c < 5; c++) step(0, make_pl(0), 0, 0, 1, $sformatf("perf_stall%0d", c));
    chk("perf_stall5", stall_cycles, 32'd5);
    step(0, make_pl(0), 1, 1, 0, "perf_flush");
    chk("perf_after_flush", stall_cycles, 32'd5);
    step(0, make_pl(0), 0, 0, 0, "perf_idle");
    chk("perf_idle", stall_cycles, 32'd5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv32v_ex_mem_skid_buffer.md
Name: rv32v_ex_mem_skid_buffer

Overview:
- Parametrised execute-to-memory pipeline stage for the vector unit.
- Replaces the fixed two-lane execute/memory payload with NUM_LANES lanes.
- Adds a two-entry skid buffer with valid/ready handshake on both sides and a flush input.
- Execute can push every cycle while memory back-pressures, with no combinational ready path from memory to execute.

Parameters:
- NUM_LANES, 2, number of vector lanes carried; must be >=1.
- OFFSET_W, 3, per-lane write-offset width; matches offset_t.
- CB_IDX_W, 3, completion-buffer index width; $clog2(NUM_CB_ENTRY).

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- flush  in  1  drop all buffered entries.
- in_valid  in  1  execute presents a payload.
- in_ready  out  1  buffer accepts the payload this cycle.
- in_load_ena  in  1  load op.
- in_store_ena  in  1  store op.
- in_wen  in  NUM_LANES  per-lane write enable.
- in_storedata  in  NUM_LANES*32  per-lane store data; lane i at [32i+31:32i].
- in_aluresult  in  NUM_LANES*32  per-lane address/ALU result.
- in_woffset  in  NUM_LANES*OFFSET_W  per-lane write offset.
- in_vd  in  5  destination vreg.
- in_eew  in  2  sew_t element width.
- in_index  in  CB_IDX_W  completion-buffer index.
- in_done  in  1  last micro-op of the instruction.
- out_valid  out  1  head entry valid.
- out_ready  in  1  memory consumes the head.
- out_*  out  (same widths as in_*)  head-entry payload: load_ena, store_ena, wen, storedata, aluresult, woffset, vd, eew, index, done.
- occupancy  out  2  entries held (0..2).

Behaviour:
- Storage: main register (drives out_*) plus skid register. FSM states are EMPTY, MAIN, FULL.
- in_ready = (state != FULL). It is registered-state only, with no combinational dependence on out_ready.
- out_valid = (state != EMPTY).
- push = in_valid & in_ready & ~flush.
- pop = out_valid & out_ready.
- EMPTY: push -> MAIN, payload loaded into main.
- MAIN:
  - push & pop -> MAIN, main reloaded.
  - push & ~pop -> FULL, payload into skid.
  - pop & ~push -> EMPTY.
  - otherwise hold.
- FULL:
  - pop -> MAIN, skid copied to main; in_valid is ignored because in_ready=0.
  - otherwise hold.
- Latency: one cycle from accepted push to out_valid when empty. Throughput is one entry per cycle.
- Ordering: strict FIFO. The skid entry never overtakes main.
- Payload stability: out_* and out_valid stay stable while out_valid & ~out_ready.
- flush: next cycle state=EMPTY and occupancy=0, regardless of push/pop the same cycle. Flush wins over push. A pop in the flush cycle is still a valid transfer on the memory side.
- Reset (RST high at any cycle, including mid-transfer):
  - State goes to EMPTY; all payload registers go to 0.
  - Next cycle: out_valid=0, in_ready=1, occupancy=0, all out_* = 0.
- Payload registers are cleared only by RST. After a flush, out_* are don't-care while out_valid=0.
- occupancy: EMPTY=0, MAIN=1, FULL=2.
- Widths are pure pass-through, with no arithmetic on payload.

Optional Feature:
- Macro RV32V_EXMEM_PERF_EN.
- Enabled: adds output stall_cycles (32 bits). It increments each cycle with out_valid & ~out_ready, saturates at 0xFFFFFFFF, and is cleared by RST only (not flush).
- Disabled: no port and no counter logic.

Decomposition:
- rv32v_ex_mem_pkg: state enum (EMPTY/MAIN/FULL) and a localparam payload-width function of NUM_LANES/OFFSET_W/CB_IDX_W. The module concatenates the payload into one vector so main/skid are single registers.
- sew_t comes from rv32i_types_pkg.
- No sub-module is required. An optional rv32v_pipe_reg (enable-loaded register of parametric width) is used for main and skid.

Test Plan:
- Reset: RST=1 for 2 cycles mid-stream with 2 entries held -> next cycle out_valid=0, in_ready=1, occupancy=0, out_storedata=0.
- Streaming, NUM_LANES=4: 8 back-to-back pushes (in_aluresult lane i = 0x1000*k+i), out_ready=1 -> outputs in order, one per cycle, first at cycle+1, occupancy stays 1.
- Back-pressure: push A, B with out_ready=0 -> occupancy=2, in_ready=0, out shows A. Then out_ready=1 -> A, then B on consecutive cycles, in_ready=1 the cycle after the first pop.
- Flush with push: state FULL, flush=1 and in_valid=1 same cycle -> next cycle out_valid=0, occupancy=0, pushed entry lost.
- Hold stability: out_ready=0 for 5 cycles with valid entry vd=7, index=3 -> out_* unchanged for all 5 cycles.
- Perf (RV32V_EXMEM_PERF_EN): 5 stall cycles then flush -> stall_cycles=5 and unchanged after flush.
